regfile_mp: RTL and testbench

//  Parametrised multi-port GPR file for the dual-issue pipeline, replacing the

---
 rtl/regfile_mp_if.sv | 38 +++
 rtl/regfile_mp.sv | 95 +++++++++
 tb/tb_regfile_mp.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_mp_if.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_mp_if
//  Brief    : Read, write and reserve bus of the multi-port GPR file.
//  Revision : 1.0 - initial release
// ============================================================================
interface regfile_mp_if #(
    parameter int NREAD  = 4,
    parameter int NWRITE = 2,
    parameter int DATA_W = 32,
    parameter int NREGS  = 32
);
    localparam int AW = $clog2(NREGS);

    logic [NREAD*AW-1:0]      read_addr;
    logic [NREAD*DATA_W-1:0]  read_data;
    logic [NREAD-1:0]         read_ready;
    logic [NWRITE-1:0]        write_ena;
    logic [NWRITE*AW-1:0]     write_addr;
    logic [NWRITE*DATA_W-1:0] write_data;
    logic [NWRITE-1:0]        rsv_ena;
    logic [NWRITE*AW-1:0]     rsv_addr;
    logic [DATA_W-1:0]        dbg_data;
    logic                     busy_any;

    // Pipeline side: issues reads, reservations and writebacks.
    modport master (
        output read_addr, write_ena, write_addr, write_data, rsv_ena, rsv_addr,
        input  read_data, read_ready, dbg_data, busy_any
    );

    // Register file side.
    modport slave (
        input  read_addr, write_ena, write_addr, write_data, rsv_ena, rsv_addr,
        output read_data, read_ready, dbg_data, busy_any
    );
endinterface
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_mp
//  Brief    : Parametrised multi-port GPR file with pending scoreboard,
//             optional write-to-read bypass and highest-port write priority.
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_mp #(
    parameter int NREAD   = 4,
    parameter int NWRITE  = 2,
    parameter int DATA_W  = 32,
    parameter int NREGS   = 32,
    parameter int BYPASS  = 1,
    parameter int DBG_REG = 16
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    regfile_mp_if.slave      bus
);
    localparam int AW = $clog2(NREGS);
    localparam logic [AW-1:0] c_ZERO_ADDR = '0;

    logic [DATA_W-1:0] r_regs [NREGS];
    logic [NREGS-1:0]  r_pending;

    logic [AW-1:0]     w_wr_addr  [NWRITE];
    logic [DATA_W-1:0] w_wr_data  [NWRITE];
    logic [AW-1:0]     w_rsv_addr [NWRITE];
    logic [AW-1:0]     w_rd_addr  [NREAD];
    logic [DATA_W-1:0] w_rd_data  [NREAD];
    logic [NREAD-1:0]  w_rd_ready;

    generate
        for (genvar j = 0; j < NWRITE; j++) begin : g_wr_unpack
            assign w_wr_addr[j]  = bus.write_addr[j*AW +: AW];
            assign w_wr_data[j]  = bus.write_data[j*DATA_W +: DATA_W];
            assign w_rsv_addr[j] = bus.rsv_addr[j*AW +: AW];
        end
    endgenerate

    // Later loop iterations overwrite earlier ones, so the highest write port
    // wins on an address collision, and reserves (second loop) beat writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NREGS; k++) begin
                r_regs[k] <= '0;
            end
            r_pending <= '0;
        end else begin
            for (int j = 0; j < NWRITE; j++) begin
                if (bus.write_ena[j] && (w_wr_addr[j] != c_ZERO_ADDR)) begin
                    r_regs[w_wr_addr[j]]    <= w_wr_data[j];
                    r_pending[w_wr_addr[j]] <= 1'b0;
                end
            end
            for (int j = 0; j < NWRITE; j++) begin
                if (bus.rsv_ena[j] && (w_rsv_addr[j] != c_ZERO_ADDR)) begin
                    r_pending[w_rsv_addr[j]] <= 1'b1;
                end
            end
        end
    end

    generate
        for (genvar i = 0; i < NREAD; i++) begin : g_read
            assign w_rd_addr[i] = bus.read_addr[i*AW +: AW];

            always_comb begin
                w_rd_data[i]  = r_regs[w_rd_addr[i]];
                w_rd_ready[i] = ~r_pending[w_rd_addr[i]];
                if (BYPASS != 0) begin
                    for (int j = 0; j < NWRITE; j++) begin
                        if (bus.write_ena[j] && (w_wr_addr[j] == w_rd_addr[i])) begin
                            w_rd_data[i]  = w_wr_data[j];
                            w_rd_ready[i] = 1'b1;
                        end
                    end
                end
                // r0 is hardwired regardless of bypass or array contents.
                if (w_rd_addr[i] == c_ZERO_ADDR) begin
                    w_rd_data[i]  = '0;
                    w_rd_ready[i] = 1'b1;
                end
            end

            assign bus.read_data[i*DATA_W +: DATA_W] = w_rd_data[i];
        end
    endgenerate

    assign bus.read_ready = w_rd_ready;
    assign bus.dbg_data   = r_regs[DBG_REG];
    assign bus.busy_any   = |r_pending;

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_mp
//  Brief    : Directed self-checking bench; drives a bypass and a no-bypass
//             instance of regfile_mp with identical stimulus.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_mp;
    localparam int NREAD  = 4;
    localparam int NWRITE = 2;
    localparam int DATA_W = 32;
    localparam int NREGS  = 32;
    localparam int AW     = 5;

    logic clk;
    logic rst_n;

    logic [NWRITE-1:0]        r_we;
    logic [NWRITE*AW-1:0]     r_wa;
    logic [NWRITE*DATA_W-1:0] r_wd;
    logic [NWRITE-1:0]        r_re;
    logic [NWRITE*AW-1:0]     r_ra;
    logic [NREAD*AW-1:0]      r_rd;

    int tests;
    int fails;

    regfile_mp_if #(.NREAD(NREAD), .NWRITE(NWRITE), .DATA_W(DATA_W), .NREGS(NREGS)) bus_b ();
    regfile_mp_if #(.NREAD(NREAD), .NWRITE(NWRITE), .DATA_W(DATA_W), .NREGS(NREGS)) bus_n ();

    assign bus_b.write_ena  = r_we;
    assign bus_b.write_addr = r_wa;
    assign bus_b.write_data = r_wd;
    assign bus_b.rsv_ena    = r_re;
    assign bus_b.rsv_addr   = r_ra;
    assign bus_b.read_addr  = r_rd;
    assign bus_n.write_ena  = r_we;
    assign bus_n.write_addr = r_wa;
    assign bus_n.write_data = r_wd;
    assign bus_n.rsv_ena    = r_re;
    assign bus_n.rsv_addr   = r_ra;
    assign bus_n.read_addr  = r_rd;

    regfile_mp #(.NREAD(NREAD), .NWRITE(NWRITE), .DATA_W(DATA_W), .NREGS(NREGS),
                 .BYPASS(1), .DBG_REG(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b.slave)
    );

    regfile_mp #(.NREAD(NREAD), .NWRITE(NWRITE), .DATA_W(DATA_W), .NREGS(NREGS),
                 .BYPASS(0), .DBG_REG(16)) dut_nb (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_n.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        r_we = '0; r_wa = '0; r_wd = '0;
        r_re = '0; r_ra = '0;
    endtask

    task automatic wr(input int p, input logic [AW-1:0] a, input logic [31:0] d);
        r_we[p] = 1'b1;
        r_wa[p*AW +: AW] = a;
        r_wd[p*DATA_W +: DATA_W] = d;
    endtask

    task automatic rsv(input int p, input logic [AW-1:0] a);
        r_re[p] = 1'b1;
        r_ra[p*AW +: AW] = a;
    endtask

    task automatic rda(input int p, input logic [AW-1:0] a);
        r_rd[p*AW +: AW] = a;
    endtask

    function automatic logic [31:0] dat_b(input int p);
        return bus_b.read_data[p*DATA_W +: DATA_W];
    endfunction

    function automatic logic [31:0] dat_n(input int p);
        return bus_n.read_data[p*DATA_W +: DATA_W];
    endfunction

    // Advance past the next rising edge; inputs change and checks happen mid-cycle.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        clr();
        r_rd = '0;

        // Reset state
        tick();
        rda(0, 5'd5);
        #1;
        check("rst_busy", {31'd0, bus_b.busy_any}, 32'd0);
        check("rst_dbg", bus_b.dbg_data, 32'd0);
        check("rst_r5_data", dat_b(0), 32'd0);
        check("rst_r5_ready", {31'd0, bus_b.read_ready[0]}, 32'd1);
        rst_n = 1'b1;

        // 1: async reset between edges wipes data and pending
        tick();
        wr(0, 5'd5, 32'hDEAD);
        rsv(1, 5'd6);
        tick();
        clr();
        #1;
        check("pre_rst_r5", dat_b(0), 32'hDEAD);
        check("pre_rst_busy", {31'd0, bus_b.busy_any}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_r5", dat_b(0), 32'd0);
        check("midrst_busy", {31'd0, bus_b.busy_any}, 32'd0);
        check("midrst_dbg", bus_b.dbg_data, 32'd0);
        // Writes presented while reset is held across an edge are dropped
        wr(0, 5'd8, 32'h55);
        rda(1, 5'd8);
        tick();
        clr();
        rst_n = 1'b1;
        #1;
        check("rst_drops_wr", dat_b(1), 32'd0);

        // 2: same-address write priority
        wr(0, 5'd7, 32'h11);
        wr(1, 5'd7, 32'h22);
        tick();
        clr();
        rda(2, 5'd7);
        #1;
        check("prio_r7_b", dat_b(2), 32'h22);
        check("prio_r7_nb", dat_n(2), 32'h22);

        // 3: bypass vs. no bypass
        wr(1, 5'd3, 32'h5);
        tick();
        clr();
        wr(0, 5'd3, 32'h9);
        rda(0, 5'd3);
        #1;
        check("byp_data", dat_b(0), 32'h9);
        check("byp_ready", {31'd0, bus_b.read_ready[0]}, 32'd1);
        check("nobyp_data", dat_n(0), 32'h5);
        check("nobyp_ready", {31'd0, bus_n.read_ready[0]}, 32'd1);
        tick();
        clr();
        #1;
        check("nobyp_next", dat_n(0), 32'h9);
        wr(0, 5'd3, 32'hA);
        wr(1, 5'd3, 32'hB);
        #1;
        check("byp_prio", dat_b(0), 32'hB);
        tick();
        clr();

        // 4: scoreboard reserve then write
        rsv(1, 5'd4);
        rda(3, 5'd4);
        #1;
        check("rsv_same_cyc", {31'd0, bus_b.read_ready[3]}, 32'd1);
        tick();
        clr();
        #1;
        check("rsv_ready", {31'd0, bus_b.read_ready[3]}, 32'd0);
        check("rsv_busy", {31'd0, bus_b.busy_any}, 32'd1);
        wr(0, 5'd4, 32'hA);
        #1;
        check("wb_byp_ready", {31'd0, bus_b.read_ready[3]}, 32'd1);
        check("wb_byp_data", dat_b(3), 32'hA);
        check("wb_nobyp_ready", {31'd0, bus_n.read_ready[3]}, 32'd0);
        tick();
        clr();
        #1;
        check("wb_ready", {31'd0, bus_b.read_ready[3]}, 32'd1);
        check("wb_data", dat_b(3), 32'hA);
        check("wb_busy", {31'd0, bus_b.busy_any}, 32'd0);

        // 5: reserve and write on the same register in one cycle
        rsv(0, 5'd9);
        wr(1, 5'd9, 32'h77);
        rda(1, 5'd9);
        tick();
        clr();
        #1;
        check("rw_data", dat_b(1), 32'h77);
        check("rw_ready", {31'd0, bus_b.read_ready[1]}, 32'd0);
        check("rw_busy", {31'd0, bus_b.busy_any}, 32'd1);
        wr(0, 5'd9, 32'h78);
        tick();
        clr();
        #1;
        check("rw_clear", {31'd0, bus_b.read_ready[1]}, 32'd1);

        // 6: r0 is hardwired, dbg_data follows r16
        wr(0, 5'd0, 32'hFFFF);
        rsv(1, 5'd0);
        rda(0, 5'd0);
        #1;
        check("r0_byp_data", dat_b(0), 32'd0);
        tick();
        clr();
        #1;
        check("r0_data", dat_b(0), 32'd0);
        check("r0_ready", {31'd0, bus_b.read_ready[0]}, 32'd1);
        check("r0_busy", {31'd0, bus_b.busy_any}, 32'd0);
        wr(1, 5'd16, 32'h1234);
        #1;
        check("dbg_before", bus_b.dbg_data, 32'd0);
        tick();
        clr();
        #1;
        check("dbg_after", bus_b.dbg_data, 32'h1234);
        check("dbg_nb", bus_n.dbg_data, 32'h1234);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
